// File: rtl/md_ctrl.sv
// Multiply/divide sequencer with HI/LO registers: computes the result at start,
// holds it pending for a fixed busy countdown, then commits it to HI/LO.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        flush,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;

    logic        go, mtgo;
    logic        is_signed;
    logic [63:0] prod;
    logic [31:0] abs_a, abs_b, quo_mag, rem_mag;
    logic [31:0] div_q, div_r;
    logic        a_neg, b_neg;
    logic [31:0] res_hi, res_lo;

    assign go   = start & ~flush & (state_q == StIdle);
    assign mtgo = mt_we & ~flush & (state_q == StIdle);

    assign is_signed = ~op[0];

    // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
    assign prod = {{32{is_signed & src_a[31]}}, src_a} * {{32{is_signed & src_b[31]}}, src_b};

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
    assign a_neg   = is_signed & src_a[31];
    assign b_neg   = is_signed & src_b[31];
    assign abs_a   = a_neg ? (32'd0 - src_a) : src_a;
    assign abs_b   = b_neg ? (32'd0 - src_b) : src_b;
    assign quo_mag = (abs_b == 32'd0) ? 32'd0 : (abs_a / abs_b);
    assign rem_mag = (abs_b == 32'd0) ? 32'd0 : (abs_a % abs_b);
    assign div_q   = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign div_r   = a_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op[1]) begin
            if (src_b == 32'd0) begin
                res_hi = hi_q;
                res_lo = lo_q;
            end else begin
                res_hi = div_r;
                res_lo = div_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    hi_pend_d = res_hi;
                    lo_pend_d = res_lo;
                    cnt_d     = op[1] ? DivLoad : MultLoad;
                    state_d   = StBusy;
                end else if (mtgo) begin
                    if (mt_sel) hi_d = mt_data;
                    else        lo_d = mt_data;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = hi_pend_q;
                    lo_d    = lo_pend_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    assign busy     = (state_q == StBusy);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = md_use_D & (busy | (start & ~flush));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed cases plus random traffic against a
// behavioural model of HI/LO and the busy window.
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mt_we, mt_sel, flush, md_use_D;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, mt_data;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data), .flush(flush),
        .md_use_D(md_use_D), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: architectural HI/LO, result waiting to land, cycles of busy left.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ch,
                                               input logic [31:0] cl);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) res = {ch, cl};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    qv = 64'(q);
                    rv = 64'(r);
                    res = {rv[31:0], qv[31:0]};
                end
            end
            default: res = (b == 32'd0) ? {ch, cl} : {a % b, a / b};
        endcase
        return res;
    endfunction

    task automatic model_edge();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start && !flush) begin
            {m_phi, m_plo} = ref_result(op, src_a, src_b, m_hi, m_lo);
            m_left = op[1] ? DIV_N : MULT_N;
        end else if (mt_we && !flush) begin
            if (mt_sel) m_hi = mt_data;
            else        m_lo = mt_data;
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0;
    endtask

    // Inputs are set just after a negedge; this checks the stall, clocks, then checks state.
    task automatic cycle();
        logic exp_stall;
        #1;
        exp_stall = md_use_D && ((m_left > 0) || (start && !flush));
        check_eq("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
    endtask

    task automatic quiet();
        start = 0; mt_we = 0; flush = 0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input int idle_n);
        start = 1; op = o; src_a = a; src_b = b; md_use_D = use_d;
        cycle();
        start = 0;
        repeat (idle_n) cycle();
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] d);
        mt_we = 1; mt_sel = sel; mt_data = d;
        cycle();
        mt_we = 0;
    endtask

    initial begin
        reset = 1; start = 0; op = 0; src_a = 0; src_b = 0; mt_we = 0; mt_sel = 0;
        mt_data = 0; flush = 0; md_use_D = 0;
        model_reset();
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // Reset mid-operation abandons the pending write.
        mt_write(1'b1, 32'hA5A5_0001);
        mt_write(1'b0, 32'h5A5A_0002);
        run_op(2'b00, 32'h1234_5678, 32'h0000_0777, 1'b0, 2);
        #2 reset = 1;
        #1;
        check_eq("async_busy", {31'd0, busy}, 32'd0);
        check_eq("async_hi", hi, 32'd0);
        check_eq("async_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        repeat (8) cycle();
        check_eq("no_late_hi", hi, 32'd0);
        check_eq("no_late_lo", lo, 32'd0);

        // mult/multu, with the D-stage stall window.
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, MULT_N);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, MULT_N);
        check_eq("multu_hi", hi, 32'h0000_0002);
        check_eq("multu_lo", lo, 32'hFFFF_FFFA);

        // Signed division, including the INT_MIN / -1 corner.
        md_use_D = 1;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, DIV_N);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_N);
        check_eq("divmin_hi", hi, 32'h0000_0000);
        check_eq("divmin_lo", lo, 32'h8000_0000);

        // Divide by zero leaves HI/LO untouched after the full countdown.
        mt_write(1'b1, 32'h0000_0011);
        mt_write(1'b0, 32'h0000_0022);
        run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 1'b1, DIV_N);
        check_eq("dz_hi", hi, 32'h0000_0011);
        check_eq("dz_lo", lo, 32'h0000_0022);

        // Flushed start and flushed mt write have no effect.
        flush = 1;
        run_op(2'b00, 32'h0000_0003, 32'h0000_0004, 1'b1, 0);
        mt_write(1'b1, 32'hDEAD_BEEF);
        flush = 0;
        check_eq("flush_hi", hi, 32'h0000_0011);
        check_eq("flush_lo", lo, 32'h0000_0022);

        // Flush during busy does not abort the operation.
        run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 1'b1, 0);
        flush = 1;
        repeat (MULT_N) cycle();
        flush = 0;
        check_eq("busyflush_hi", hi, 32'h0000_0000);
        check_eq("busyflush_lo", lo, 32'h0000_000C);

        // Random traffic, including requests while busy and start+mt_we together.
        for (int i = 0; i < 1500; i++) begin
            int pick;
            start    = ($urandom_range(0, 3) == 0);
            mt_we    = ($urandom_range(0, 3) == 0);
            mt_sel   = 1'($urandom);
            mt_data  = $urandom;
            flush    = ($urandom_range(0, 5) == 0);
            md_use_D = 1'($urandom);
            op       = 2'($urandom);
            src_a    = $urandom;
            src_b    = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) src_b = 32'd0;
            if (pick == 1) begin src_a = 32'h8000_0000; src_b = 32'hFFFF_FFFF; end
            if (pick == 2) src_b = 32'($urandom_range(1, 9));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
